// File: rtl/feature_pkg.sv
// Shared defaults, derived widths and FSM state encodings for the feature-weight loader.
package feature_pkg;

  localparam int unsigned KERNEL_SIZE  = 3;
  localparam int unsigned NUM_FEATURES = 10;
  localparam int unsigned K2           = KERNEL_SIZE * KERNEL_SIZE;

  // Address needs one spare bit so the feature counter can reach NUM_FEATURES.
  function automatic int unsigned addr_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  localparam int unsigned ADDR_W = addr_width(NUM_FEATURES);

  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StShift = 3'd1;
  localparam state_t StCheck = 3'd2;
  localparam state_t StWrite = 3'd3;
  localparam state_t StDone  = 3'd4;

endpackage

// File: rtl/bit_deserializer.sv
// Indexed store of a bit-serial kernel with bit counter, last-bit flag and running parity.
module bit_deserializer #(
  parameter int unsigned Bits     = 9,
  parameter int unsigned ParityEn = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic valid_i,
  input  logic bit_i,
  output logic data_o [Bits],
  output logic last_o,
  output logic parity_o
);

  localparam int unsigned Total = Bits + ParityEn;
  localparam int unsigned CntW  = $clog2(Bits) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            par_q, par_d;
  logic            buf_q [Bits];
  logic            buf_d [Bits];

  always_comb begin
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    last_o   = valid_i && (cnt_q == CntW'(Total - 1));
    parity_o = par_q ^ bit_i;
    if (clear_i) begin
      cnt_d = '0;
      par_d = 1'b0;
    end else if (valid_i) begin
      // The trailing parity bit (cnt_q == Bits) matches no slot and is not stored.
      for (int unsigned i = 0; i < Bits; i++) begin
        if (cnt_q == CntW'(i)) buf_d[i] = bit_i;
      end
      if (last_o) begin
        cnt_d = '0;
        par_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        par_d = parity_o;
      end
    end
  end

  // Next-state view so the top can latch the kernel on the same edge as the last bit.
  assign data_o = buf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      par_q <= 1'b0;
      buf_q <= '{default: 1'b0};
    end else begin
      cnt_q <= cnt_d;
      par_q <= par_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/feature_loader.sv
// Bit-serial to kernel loader driving the feature memory write port, one strobe per kernel.
// Define FEATURE_LOADER_PARITY_EN to accept a trailing even-parity bit per kernel and check it.
module feature_loader
  import feature_pkg::*;
#(
  parameter int unsigned KernelSize  = KERNEL_SIZE,
  parameter int unsigned NumFeatures = NUM_FEATURES
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  in_bit,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [addr_width(NumFeatures)-1:0]    address_w,
  output logic                                  feature_WrEn,
  output logic                                  weights_input [KernelSize*KernelSize],
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int unsigned Kk    = KernelSize * KernelSize;
  localparam int unsigned AddrW = addr_width(NumFeatures);
`ifdef FEATURE_LOADER_PARITY_EN
  localparam int unsigned ParityEn = 1;
`else
  localparam int unsigned ParityEn = 0;
`endif

  state_t           state_q, state_d;
  logic [AddrW-1:0] feat_cnt_q, feat_cnt_d;
  logic [AddrW-1:0] address_q;
  logic             err_q, err_d;
  logic             in_ready_q, wren_q, busy_q, done_q;
  logic             weights_q [Kk];
  logic             kernel [Kk];
  logic             clear, xfer, last, kernel_parity, feat_last;

  assign xfer      = in_valid && in_ready_q;
  assign feat_last = (feat_cnt_q == AddrW'(NumFeatures - 1));

  bit_deserializer #(
    .Bits     (Kk),
    .ParityEn (ParityEn)
  ) u_deser (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (clear),
    .valid_i  (xfer),
    .bit_i    (in_bit),
    .data_o   (kernel),
    .last_o   (last),
    .parity_o (kernel_parity)
  );

`ifdef FEATURE_LOADER_PARITY_EN
  logic par_bad_q, par_bad_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_bad_q <= 1'b0;
    else      par_bad_q <= par_bad_d;
  end
`else
  logic unused_parity;
  assign unused_parity = kernel_parity;
`endif

  always_comb begin
    state_d    = state_q;
    feat_cnt_d = feat_cnt_q;
    err_d      = err_q;
    clear      = 1'b0;
`ifdef FEATURE_LOADER_PARITY_EN
    par_bad_d  = par_bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StShift;
          clear      = 1'b1;
          feat_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      StShift: begin
        if (last) begin
`ifdef FEATURE_LOADER_PARITY_EN
          state_d   = StCheck;
          par_bad_d = kernel_parity;
`else
          state_d   = StWrite;
`endif
        end
      end
`ifdef FEATURE_LOADER_PARITY_EN
      StCheck: begin
        if (par_bad_q) begin
          // Bad kernel: skip the strobe but still consume its address slot.
          err_d      = 1'b1;
          feat_cnt_d = feat_cnt_q + 1'b1;
          state_d    = feat_last ? StDone : StShift;
        end else begin
          state_d = StWrite;
        end
      end
`endif
      StWrite: begin
        feat_cnt_d = feat_cnt_q + 1'b1;
        state_d    = feat_last ? StDone : StShift;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so the memory sees clean levels at negedge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      feat_cnt_q <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      wren_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      address_q  <= '0;
      weights_q  <= '{default: 1'b0};
    end else begin
      state_q    <= state_d;
      feat_cnt_q <= feat_cnt_d;
      err_q      <= err_d;
      in_ready_q <= (state_d == StShift);
      wren_q     <= (state_d != StWrite);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
      if (state_d == StWrite) begin
        address_q <= feat_cnt_q;
        weights_q <= kernel;
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign feature_WrEn  = wren_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign address_w     = address_q;
  assign weights_input = weights_q;
`ifdef FEATURE_LOADER_PARITY_EN
  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_feature_loader.sv
// Scoreboard bench for feature_loader: expected writes queued by stimulus, checked by a monitor.
module tb_feature_loader;

  localparam int unsigned K  = 3;
  localparam int unsigned N  = 10;
  localparam int unsigned KK = K * K;
  localparam int unsigned AW = $clog2(N) + 1;
`ifdef FEATURE_LOADER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [KK-1:0] kern;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_bit = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] address_w;
  logic          feature_WrEn;
  logic          weights_input [KK];
  logic          busy, done, err;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  strobes = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  bit  abort = 1'b0;

  feature_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_bit        (in_bit),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .address_w     (address_w),
    .feature_WrEn  (feature_WrEn),
    .weights_input (weights_input),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [KK-1:0] packw();
    logic [KK-1:0] v;
    for (int i = 0; i < KK; i++) v[i] = weights_input[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the expected-write queue.
  initial begin
    logic prev_wren;
    wr_t  e;
    prev_wren = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && !feature_WrEn) begin
        strobes++;
        chk("in_ready_low_in_write", 32'(in_ready), 32'd0);
        chk("wren_not_consecutive", 32'(prev_wren), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe got addr %0d expected no write", address_w);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(address_w), 32'(e.addr));
          chk("write_kernel", 32'(packw()), 32'(e.kern));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_wren = feature_WrEn;
    end
  end

  // Called just after a posedge; returns just after the posedge that took the bit.
  task automatic send_bit(input logic b, input bit stall);
    bit ok;
    if (abort) return;
    if (stall) begin
      for (int s = 0; s < 8 && $urandom_range(0, 1) == 1; s++) begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_bit   = b;
    ok       = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      abort = 1'b1;
      $display("FAIL in_ready_timeout got 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic run_load(input int mul, input int add, input bit stall, input int bad_idx,
                          input bit pulse_start, input bit check_timing);
    logic [KK-1:0] kern [N];
    int            start_cyc, d0, t;
    d0 = done_cnt;
    for (int f = 0; f < N; f++) begin
      kern[f] = KK'(f * mul + add);
      if (f != bad_idx) exp_q.push_back('{addr: AW'(f), kern: kern[f]});
    end
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_cleared_at_start", 32'(err), 32'd0);
    for (int f = 0; f < N; f++) begin
      if (pulse_start && f == 5) start = 1'b1;
      for (int i = 0; i < KK; i++) begin
        send_bit(kern[f][i], stall);
        start = 1'b0;
      end
      if (PB == 1) send_bit((^kern[f]) ^ (f == bad_idx), stall);
    end
    t = 0;
    while (done_cnt == d0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    if (check_timing)
      chk("done_latency", 32'(done_cyc - start_cyc), 32'(1 + N * (KK + 1 + PB)));
  endtask

  initial begin
    int s0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_address", 32'(address_w), 32'd0);
    chk("rst_wren", 32'(feature_WrEn), 32'd1);
    chk("rst_weights", 32'(packw()), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Run A: kernel f = value f, no stalls, exact run length
    run_load(1, 0, 1'b0, -1, 1'b0, 1'b1);
    // Run B back-to-back: random stalls, start pulsed while busy, bad parity on kernel 3
    run_load(73, 11, 1'b1, (PB == 1) ? 3 : -1, 1'b1, 1'b0);
    chk("err_after_run_b", 32'(err), 32'(PB));
    // Run C back-to-back: err must clear, addresses restart at 0
    run_load(29, 300, 1'b0, -1, 1'b0, 1'b1);
    chk("err_after_run_c", 32'(err), 32'd0);
    chk("weights_hold_last", 32'(packw()), 32'(KK'(9 * 29 + 300)));
    chk("address_hold_last", 32'(address_w), 32'(N - 1));

    // Asynchronous reset mid-SHIFT after 4 bits
    s0    = strobes;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrun_rst_wren", 32'(feature_WrEn), 32'd1);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd0);
    chk("midrun_rst_weights", 32'(packw()), 32'd0);
    chk("midrun_rst_address", 32'(address_w), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("no_restart_without_start", 32'(busy), 32'd0);
    chk("no_write_after_rst", 32'(strobes - s0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/feature_loader.md
# feature_loader

Serial-to-parallel loader that feeds the binary feature-weight memory of the CNN core. Accepts a bit-serial weight stream over a valid/ready handshake, assembles one KERNEL_SIZE×KERNEL_SIZE kernel at a time, and issues one active-low write strobe per kernel to the feature memory, stepping the address from 0 to NUM_FEATURES-1. It sits between the off-chip/configuration interface and the feature memory, and runs once per network load.

## Interface
- KERNEL_SIZE, 3, kernel edge; kernel holds KERNEL_SIZE*KERNEL_SIZE one-bit weights
- NUM_FEATURES, 10, number of kernels loaded per run
- clk  in  1  main chip clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a load run; sampled only in IDLE
- in_bit  in  1  serial weight bit
- in_valid  in  1  in_bit is valid
- in_ready  out  1  loader accepts in_bit this cycle
- address_w  out  $clog2(NUM_FEATURES)+1  feature-memory write address
- feature_WrEn  out  1  write strobe to feature memory, active-low
- weights_input  out  1×(KERNEL_SIZE*KERNEL_SIZE) unpacked  assembled kernel
- busy  out  1  high from start acceptance until DONE exit
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky parity error (parity build only; tied 0 otherwise)

## Operation
- States: IDLE, SHIFT, CHECK (parity build only), WRITE, DONE.
- IDLE: in_ready=0; start=1 -> SHIFT, clear bit_cnt, feat_cnt, err; busy=1.
- SHIFT: in_ready=1; on in_valid&&in_ready, bit stored at weights_input[bit_cnt], bit_cnt++. Bit 0 of the stream is weights_input[0] (row-major, top-left first). When bit_cnt reaches K*K-1 with a transfer -> WRITE (or CHECK).
- WRITE: exactly one cycle; feature_WrEn=0, address_w=feat_cnt, in_ready=0. Then feat_cnt++; if feat_cnt was NUM_FEATURES-1 -> DONE else SHIFT with bit_cnt=0.
- DONE: done=1 for one cycle, -> IDLE, busy=0.
- in_valid low in SHIFT: hold state, no count change (stalls of any length allowed).
- start while busy: ignored.
- address_w never exceeds NUM_FEATURES-1; outputs held stable outside WRITE (address_w holds last value, weights_input holds last kernel).
- Counters: bit_cnt width $clog2(K*K)+1, feat_cnt width matches address_w; no wrap beyond terminal values.

## Timing
- Reset values: in_ready=0, address_w=0, feature_WrEn=1, weights_input all 0, busy=0, done=0, err=0; state IDLE.
- All outputs registered off posedge; the feature memory samples on negedge, so address_w, weights_input and feature_WrEn are stable a half cycle before capture.
- Minimum run length with no stalls: 1 (start) + NUM_FEATURES×(K*K + 1 [+1 CHECK]) + 1 (DONE) cycles.
- rst asserted mid-run: immediate return to reset values; feature_WrEn forced high asynchronously so no partial kernel is written; restart requires new start.
- feature_WrEn low for exactly one clk per kernel, never two consecutive cycles.

## Configuration
- FEATURE_LOADER_PARITY_EN defined: after the K*K data bits one extra bit (even parity over the kernel) is accepted in SHIFT; CHECK state compares. Match -> WRITE. Mismatch -> skip WRITE, set err (sticky until next start), feat_cnt still advances, address not written.
- Undefined: no parity bit, no CHECK state, err tied 0.

## Structure
- Shared package feature_pkg: KERNEL_SIZE/NUM_FEATURES defaults, derived K2 = KERNEL_SIZE*KERNEL_SIZE, address width localparam, loader state enum.
- One sub-module: bit_deserializer (indexed shift/store of K2 bits with bit counter and full flag); FSM and write strobe stay in feature_loader.

## Test plan
- Reset: rst=0 mid-SHIFT after 4 bits -> feature_WrEn=1, busy=0, weights_input all 0, no write observed.
- Full load, K=3, N=10, no stalls: kernel f bits = 9-bit value f (LSB first) -> 10 strobes, address_w 0..9, weights_input[0..8] match, done after 102 cycles.
- Random in_valid stalls (50%) -> identical memory contents, no extra strobes, in_ready never high in WRITE.
- start pulsed during busy -> ignored, feat_cnt unaffected, single done.
- Parity build: bad parity on kernel 3 -> err=1, addresses 0–2,4–9 written, address 3 not strobed.
- Back-to-back runs: start in cycle after done -> second run begins, err cleared, address restarts at 0.
